// File: rtl/irq_pending_ctrl.sv
// Eight-source interrupt pending capture with masking, fixed priority (bit 7 highest)
// and a valid/ready presentation of the winning source ID.
module irq_pending_ctrl #(
   parameter bit EDGE_DETECT = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req_in,
   input  logic [7:0] mask,
   output logic       irq_valid,
   output logic [2:0] irq_id,
   input  logic       irq_ready,
   output logic [7:0] pending,
   output logic       overflow,
   input  logic       clr_ovf
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] PRESENT = 1'b1;

   logic [0:0] state_reg;
   logic [7:0] req_d_reg;
   logic [7:0] pending_reg;
   logic       valid_reg;
   logic [2:0] id_reg;
   logic       ovf_reg;

   logic [7:0] set_vec;
   logic [7:0] clear_vec;
   logic [7:0] pending_next;
   logic [7:0] eligible;
   logic [2:0] winner;
   logic       handshake;
   logic       ovf_hit;

   assign handshake = (state_reg == PRESENT) && irq_ready;
   assign eligible  = pending_reg & ~mask;

   // A new request wins over a same-cycle clear, so it is never lost.
   for (genvar gi = 0; gi < 8; gi++) begin : g_bit
      assign set_vec[gi]      = EDGE_DETECT ? (req_in[gi] & ~req_d_reg[gi]) : req_in[gi];
      assign clear_vec[gi]    = handshake && (id_reg == 3'(gi));
      assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clear_vec[gi]);
   end

   // In level mode a held line re-sets every cycle, which is not an overflow.
   assign ovf_hit = EDGE_DETECT && (|(set_vec & pending_reg & ~clear_vec));

   always_comb begin
      winner = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (eligible[i]) winner = 3'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         req_d_reg   <= req_in;
         pending_reg <= 8'h00;
         valid_reg   <= 1'b0;
         id_reg      <= 3'd0;
         ovf_reg     <= 1'b0;
      end else begin
         req_d_reg   <= req_in;
         pending_reg <= pending_next;
         if (clr_ovf)
            ovf_reg <= 1'b0;
         else if (ovf_hit)
            ovf_reg <= 1'b1;
         case (state_reg)
            IDLE: begin
               if (eligible != 8'h00) begin
                  id_reg    <= winner;
                  valid_reg <= 1'b1;
                  state_reg <= PRESENT;
               end
            end
            default: begin
               // The presented ID is held until accepted, whatever the mask does.
               if (irq_ready) begin
                  valid_reg <= 1'b0;
                  state_reg <= IDLE;
               end
            end
         endcase
      end
   end

   assign irq_valid = valid_reg;
   assign irq_id    = id_reg;
   assign pending   = pending_reg;
   assign overflow  = ovf_reg;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: one edge-mode and one level-mode instance.
module tb_irq_pending_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req_in, mask;
   logic       irq_ready, clr_ovf;
   logic       irq_valid, overflow;
   logic [2:0] irq_id;
   logic [7:0] pending;

   logic [7:0] req_l;
   logic       ready_l;
   logic       valid_l, ovf_l;
   logic [2:0] id_l;
   logic [7:0] pending_l;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   irq_pending_ctrl #(.EDGE_DETECT(1'b1)) u_edge (
      .clk(clk), .rst(rst), .req_in(req_in), .mask(mask),
      .irq_valid(irq_valid), .irq_id(irq_id), .irq_ready(irq_ready),
      .pending(pending), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   irq_pending_ctrl #(.EDGE_DETECT(1'b0)) u_level (
      .clk(clk), .rst(rst), .req_in(req_l), .mask(8'h00),
      .irq_valid(valid_l), .irq_id(id_l), .irq_ready(ready_l),
      .pending(pending_l), .overflow(ovf_l), .clr_ovf(1'b0)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
         end
      $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic chk_edge(input string tag, input logic v, input logic [2:0] id,
                           input logic [7:0] p);
      chk({tag, ".valid"}, 32'(irq_valid), 32'(v));
      if (v) chk({tag, ".id"}, 32'(irq_id), 32'(id));
      chk({tag, ".pend"}, 32'(pending), 32'(p));
   endtask

   initial begin
      rst = 1'b1; req_in = 8'h00; mask = 8'h00; irq_ready = 1'b0; clr_ovf = 1'b0;
      req_l = 8'h00; ready_l = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("rst.valid", 32'(irq_valid), 0);
      chk("rst.id",    32'(irq_id), 0);
      chk("rst.pend",  32'(pending), 0);
      chk("rst.ovf",   32'(overflow), 0);

      // Single edge on bit 3
      irq_ready = 1'b1; req_in = 8'h08;
      tick(); chk_edge("e1.k0", 1'b0, 3'd0, 8'h08);
      tick(); chk_edge("e1.k1", 1'b1, 3'd3, 8'h08);
      tick(); chk_edge("e1.k2", 1'b0, 3'd0, 8'h00);
      req_in = 8'h00;
      tick();

      // Priority and serialization 7,5,0
      req_in = 8'hA1;
      tick(); chk_edge("pr.0", 1'b0, 3'd0, 8'hA1);
      tick(); chk_edge("pr.1", 1'b1, 3'd7, 8'hA1);
      tick(); chk_edge("pr.2", 1'b0, 3'd0, 8'h21);
      tick(); chk_edge("pr.3", 1'b1, 3'd5, 8'h21);
      tick(); chk_edge("pr.4", 1'b0, 3'd0, 8'h01);
      tick(); chk_edge("pr.5", 1'b1, 3'd0, 8'h01);
      tick(); chk_edge("pr.6", 1'b0, 3'd0, 8'h00);
      req_in = 8'h00;
      tick();

      // Mask bit 7, stall, unmask mid-stall, then accept
      mask = 8'h80; irq_ready = 1'b0; req_in = 8'h81;
      tick(); chk_edge("mk.0", 1'b0, 3'd0, 8'h81);
      tick(); chk_edge("mk.1", 1'b1, 3'd0, 8'h81);
      mask = 8'h00;
      for (int i = 0; i < 5; i++) begin
         tick(); chk_edge("mk.stall", 1'b1, 3'd0, 8'h81);
      end
      irq_ready = 1'b1;
      tick(); chk_edge("mk.acc0", 1'b0, 3'd0, 8'h80);
      tick(); chk_edge("mk.pres7", 1'b1, 3'd7, 8'h80);
      tick(); chk_edge("mk.acc7", 1'b0, 3'd0, 8'h00);
      req_in = 8'h00; irq_ready = 1'b0;
      tick();

      // Overflow on bit 2 while masked, then clear
      mask = 8'h04; req_in = 8'h04;
      tick(); chk("ov.pend", 32'(pending), 32'h04);
      chk("ov.pre", 32'(overflow), 0);
      req_in = 8'h00;
      tick();
      req_in = 8'h04;
      tick(); chk("ov.set", 32'(overflow), 1);
      req_in = 8'h00; clr_ovf = 1'b1;
      tick(); chk("ov.clr", 32'(overflow), 0);
      clr_ovf = 1'b0;

      // Set wins over same-cycle clear of ID 2
      mask = 8'h00; irq_ready = 1'b1;
      tick(); chk_edge("sw.pres", 1'b1, 3'd2, 8'h04);
      req_in = 8'h04;
      tick(); chk_edge("sw.hs", 1'b0, 3'd0, 8'h04);
      chk("sw.ovf", 32'(overflow), 0);
      tick(); chk_edge("sw.again", 1'b1, 3'd2, 8'h04);
      tick(); chk_edge("sw.done", 1'b0, 3'd0, 8'h00);
      req_in = 8'h00;
      tick();

      // Reset during presentation with all lines held high
      irq_ready = 1'b0; req_in = 8'hFF;
      tick(); chk_edge("rm.0", 1'b0, 3'd0, 8'hFF);
      tick(); chk_edge("rm.1", 1'b1, 3'd7, 8'hFF);
      rst = 1'b1;
      tick(); chk_edge("rm.rst", 1'b0, 3'd0, 8'h00);
      chk("rm.ovf", 32'(overflow), 0);
      rst = 1'b0; irq_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(); chk_edge("rm.hold", 1'b0, 3'd0, 8'h00);
      end
      req_in = 8'h00;

      // Level mode: bit 4 held high re-presents every 2 cycles
      ready_l = 1'b1; req_l = 8'h10;
      tick();
      chk("lv.pend0", 32'(pending_l), 32'h10);
      chk("lv.valid0", 32'(valid_l), 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("lv.valid", 32'(valid_l), 32'((i % 2) == 0));
         if ((i % 2) == 0) chk("lv.id", 32'(id_l), 4);
         chk("lv.pend", 32'(pending_l), 32'h10);
         chk("lv.ovf", 32'(ovf_l), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Eight-source interrupt pending-capture and presentation stage that feeds priority-encoded interrupt IDs to a downstream consumer. It detects requests on eight lines (edge or level), holds them in a pending register, and applies a per-source mask. It selects the highest-priority unmasked source (bit 7 highest, bit 0 lowest), which is the same priority order as the team's 8-to-3 encoder. The selected 3-bit ID is presented over a valid/ready handshake, and the served pending bit is cleared on acceptance.

## Interface
- EDGE_DETECT, 1, 1 = a rising edge on req_in[i] sets pending[i]; 0 = level mode, req_in[i] high sets pending[i] on every cycle.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_in  input  8  request lines, synchronous to clk.
- mask  input  8  1 = source masked; the source stays pending but cannot be selected.
- irq_valid  output  1  presented ID is valid.
- irq_id  output  3  index of the presented source.
- irq_ready  input  1  consumer accepts irq_id when irq_valid & irq_ready at a clock edge.
- pending  output  8  current pending register, unmasked view.
- overflow  output  1  sticky flag: a new request arrived on a source that was already pending.
- clr_ovf  input  1  clears overflow.

## Operation
- Reset (rst high at an edge):
  - pending = 0, irq_valid = 0, irq_id = 0, overflow = 0, state = IDLE.
  - The edge-detect history register loads req_in, so a line held high through reset produces no edge.
- Set condition for source i:
  - EDGE_DETECT = 1: req_in[i] & ~req_d[i].
  - EDGE_DETECT = 0: req_in[i].
- Clear condition for source i: a handshake this cycle and irq_id == i.
- Pending update: pending[i] <= set[i] | (pending[i] & ~clear[i]). Set wins over a same-cycle clear, so the new request stays pending.
- Overflow:
  - overflow <= 1 when set[i] & pending[i] & ~clear[i] for any i.
  - clr_ovf has priority over a same-cycle set of overflow.
  - In level mode, overflow is not evaluated and stays 0.
- Selection: eligible = pending & ~mask. The winner is the highest set bit of eligible.
- FSM, two states:
  - IDLE: if eligible != 0, register irq_id = winner, set irq_valid = 1, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: irq_id and irq_valid are held stable regardless of mask changes or new higher-priority arrivals; a presentation is never withdrawn. On irq_ready, set irq_valid = 0 and go to IDLE.
- Consequence: at least one IDLE cycle separates consecutive presentations, so the maximum rate is one ID every 2 cycles.
- Masking a source while it is being presented does not cancel the presentation; acceptance still clears its pending bit.
- irq_ready while in IDLE is ignored.

## Timing
- Request to presentation:
  - req_in[i] rises and is sampled at edge k, so pending[i] = 1 after edge k.
  - With the FSM in IDLE and source i the winner, irq_valid = 1 and irq_id = i after edge k+1.
  - Total latency: 2 cycles.
- Handshake at edge m: after edge m, irq_valid = 0 and pending[irq_id] = 0 (unless re-set at edge m). The earliest next irq_valid is after edge m+1.
- The pending output is registered; it is not a combinational function of req_in.
- Reset mid-presentation: irq_valid drops and all pending bits are lost after the reset edge. A line still high after reset is not re-captured in edge mode.

## Test plan
- Single edge, EDGE_DETECT = 1: req_in = 0x08 rising at edge 0, irq_ready = 1.
  - Required: pending = 0x08 after edge 0; irq_valid = 1 and irq_id = 3 after edge 1.
  - Required: pending = 0x00 and irq_valid = 0 after edge 2.
- Priority and serialization: req_in 0x00 -> 0xA1 in one cycle, irq_ready = 1.
  - Required: IDs presented in order 7, 5, 0, each valid for one cycle, separated by one idle cycle.
  - Required: pending goes 0xA1 -> 0x21 -> 0x01 -> 0x00.
- Mask and stall:
  - mask = 0x80 with pending 0x81: required irq_id = 0.
  - Hold irq_ready = 0 for 5 cycles while pending[7] rises: required irq_id stays 0 and irq_valid stays 1.
  - Unmask and accept: required next irq_id = 7.
- Overflow and set-wins-over-clear:
  - A second rising edge on bit 2 while pending[2] = 1 and not presented: required overflow = 1; clr_ovf pulse returns it to 0.
  - An edge on bit 2 in the same cycle as the handshake for ID 2: required pending[2] stays 1 and ID 2 is presented again.
- Reset mid-operation: assert rst during PRESENT with req_in = 0xFF held.
  - Required after reset: irq_valid = 0, pending = 0, overflow = 0.
  - Required: no new presentation occurs while req_in stays 0xFF (edge mode).
- Level mode, EDGE_DETECT = 0: req_in[4] held high, irq_ready = 1.
  - Required: ID 4 is re-presented every 2 cycles.
  - Required: pending[4] never drops while req_in[4] = 1, and overflow stays 0.
